mod_mul_pipe: RTL and testbench

// Pipelined Barrett modular multiplier: c_o = (a_i * b_i) mod q_i for a 23-bit prime q.

---
 rtl/mod_mul_pipe_if.sv | 27 ++
 rtl/mod_mul_pipe.sv | 63 ++++++
 tb/tb_mod_mul_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_mul_pipe_if.sv
// Operand/result bus of the Barrett modular multiplier: request side (operands, modulus, tag)
// and response side (product, tag), each with its own valid/ready pair.
interface mod_mul_pipe_if #(
  parameter int TAG_W = 8
);
  logic [22:0]      a_i;
  logic [22:0]      b_i;
  logic [22:0]      q_i;
  logic [23:0]      mu_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_i;
  logic             ready_o;
  logic [22:0]      c_o;
  logic [TAG_W-1:0] tag_o;
  logic             valid_o;
  logic             ready_i;

  modport slave (
    input  a_i, b_i, q_i, mu_i, tag_i, valid_i, ready_i,
    output ready_o, c_o, tag_o, valid_o
  );

  modport master (
    output a_i, b_i, q_i, mu_i, tag_i, valid_i, ready_i,
    input  ready_o, c_o, tag_o, valid_o
  );
endinterface

// File: rtl/mod_mul_pipe.sv
// Barrett modular multiplier c = a*b mod q (23-bit q): 4-stage pipeline, 1 op/cycle.
// Global stall: all stages advance only when the output is empty or being drained.
module mod_mul_pipe #(
  parameter int TAG_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mod_mul_pipe_if.slave io
);

  logic             en;
  logic             v1, v2, v3;
  logic [45:0]      x1;
  logic [24:0]      x2;
  logic [23:0]      t2;
  logic [24:0]      r3;
  logic [TAG_W-1:0] g1, g2, g3;
  logic [47:0]      tmul;
  logic [24:0]      tq;
  logic [24:0]      qx;
  logic [24:0]      r1;
  logic [24:0]      cr;

  assign en         = !io.valid_o || io.ready_i;
  assign io.ready_o = en;

  // Quotient estimate from the top bits of x; undershoots the true quotient by at most 2.
  assign tmul = 48'(x1[45:22]) * 48'(io.mu_i);
  // Only the low 25 bits of t*q matter since the remainder is known to fit below 3q.
  assign tq   = 25'(t2) * 25'(io.q_i);
  assign qx   = 25'(io.q_i);
  assign r1   = (r3 >= qx) ? r3 - qx : r3;
  assign cr   = (r1 >= qx) ? r1 - qx : r1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      io.valid_o <= 1'b0;
      io.c_o     <= '0;
      io.tag_o   <= '0;
    end else if (en) begin
      v1         <= io.valid_i;
      x1         <= 46'(io.a_i) * 46'(io.b_i);
      g1         <= io.tag_i;

      v2         <= v1;
      t2         <= 24'(tmul >> 24);
      x2         <= x1[24:0];
      g2         <= g1;

      v3         <= v2;
      r3         <= x2 - tq;
      g3         <= g2;

      io.valid_o <= v3;
      io.c_o     <= 23'(cr);
      io.tag_o   <= g3;
    end
  end

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Bench for mod_mul_pipe: directed literal vectors plus streamed random ops checked
// against a queue model computing (a*b)%q at accept time.
`timescale 1ns/1ps
module tb_mod_mul_pipe;

  localparam int          TAG_W = 8;
  localparam logic [22:0] Q1    = 23'd8380417;
  localparam logic [23:0] MU1   = 24'd8396807;
  localparam logic [22:0] Q2    = 23'd4194319;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_mul_pipe_if #(.TAG_W(TAG_W)) bus ();

  mod_mul_pipe #(.TAG_W(TAG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  typedef struct {
    logic [22:0]      exp;
    logic [TAG_W-1:0] tag;
    logic [22:0]      q;
    int               acc;
    bit               lat;
  } ent_t;

  ent_t mq[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   last_pop = 0;
  bit   lat_mode = 1'b1;
  bit   rnd_rdy  = 1'b0;

  logic             p_vld = 1'b0;
  logic             p_rdy = 1'b1;
  logic             p_rst = 1'b1;
  logic [22:0]      p_c   = '0;
  logic [TAG_W-1:0] p_tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [22:0] rnd_op(input logic [22:0] q);
    return 23'($urandom_range(32'(q) - 32'd1, 0));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.ready_i = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Scoreboard: push on accepted input, pop on drained output, check stall rules.
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      mq.delete();
    end else begin
      if (!p_rst && p_vld && !p_rdy) begin
        chk("hold_valid", 64'(bus.valid_o), 64'd1);
        chk("hold_c", 64'(bus.c_o), 64'(p_c));
        chk("hold_tag", 64'(bus.tag_o), 64'(p_tag));
      end
      if (bus.valid_o && !bus.ready_i) chk("ready_o_stalled", 64'(bus.ready_o), 64'd0);
      if (!bus.valid_o) chk("ready_o_empty", 64'(bus.ready_o), 64'd1);
      if (bus.valid_o && bus.ready_i) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got c_o=%0d tag_o=%0d, expected no output (cycle %0d)",
                   bus.c_o, bus.tag_o, cyc);
        end else begin
          e = mq.pop_front();
          chk("c_o", 64'(bus.c_o), 64'(e.exp));
          chk("tag_o", 64'(bus.tag_o), 64'(e.tag));
          chk("c_below_q", 64'(bus.c_o < e.q), 64'd1);
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd4);
          last_pop = cyc;
        end
      end
      if (bus.valid_i && bus.ready_o) begin
        e.exp = 23'((64'(bus.a_i) * 64'(bus.b_i)) % 64'(bus.q_i));
        e.tag = bus.tag_i;
        e.q   = bus.q_i;
        e.acc = cyc;
        e.lat = lat_mode;
        mq.push_back(e);
        last_acc = cyc;
      end
    end
    p_vld = bus.valid_o;
    p_rdy = bus.ready_i;
    p_rst = rst;
    p_c   = bus.c_o;
    p_tag = bus.tag_o;
  end

  // Presents one op and returns one cycle after it is accepted, valid_i still high.
  task automatic send(input logic [22:0] a, input logic [22:0] b, input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.tag_i   = t;
    bus.valid_i = 1'b1;
    @(negedge clk);
    while (!bus.ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready_o=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.valid_i = 1'b0;
    while (mq.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d ops pending, expected 0", mq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic direct(input string name, input logic [22:0] a, input logic [22:0] b,
                        input logic [TAG_W-1:0] t, input logic [22:0] exp);
    int k;
    k = 0;
    send(a, b, t);
    bus.valid_i = 1'b0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.valid_o && k < 20);
    chk({name, "_c"}, 64'(bus.c_o), 64'(exp));
    chk({name, "_tag"}, 64'(bus.tag_o), 64'(t));
    chk({name, "_lat"}, 64'(k), 64'd4);
    drain();
  endtask

  initial begin
    int s0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.tag_i   = '0;
    bus.valid_i = 1'b0;
    bus.q_i     = Q1;
    bus.mu_i    = MU1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid_o", 64'(bus.valid_o), 64'd0);
    chk("reset_c_o", 64'(bus.c_o), 64'd0);
    chk("reset_tag_o", 64'(bus.tag_o), 64'd0);
    chk("reset_ready_o", 64'(bus.ready_o), 64'd1);
    @(posedge clk);
    #1;

    direct("qm1_sq", Q1 - 23'd1, Q1 - 23'd1, 8'h11, 23'd1);
    direct("pow22_x2", 23'd4194304, 23'd2, 8'h21, 23'd8191);
    direct("zero", 23'd0, 23'd1234567, 8'h22, 23'd0);
    direct("one_x_qm1", 23'd1, Q1 - 23'd1, 8'h23, 23'd8380416);
    direct("qm1_x2", Q1 - 23'd1, 23'd2, 8'h24, 23'd8380415);

    s0 = cyc;
    for (int i = 0; i < 1000; i++) send(rnd_op(Q1), rnd_op(Q1), 8'(i));
    chk("stream_accept_span", 64'(last_acc - s0), 64'd999);
    drain();
    chk("stream_last_latency", 64'(last_pop - last_acc), 64'd4);

    lat_mode = 1'b0;
    rnd_rdy  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rnd_op(Q1), rnd_op(Q1), 8'(i + 7));
    end
    drain();
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lat_mode = 1'b1;

    for (int i = 0; i < 6; i++) send(rnd_op(Q1), rnd_op(Q1), 8'(8'hA0 + i));
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("midrst_c_o", 64'(bus.c_o), 64'd0);
    chk("midrst_tag_o", 64'(bus.tag_o), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_pending", 64'(mq.size()), 64'd0);
    direct("post_rst", Q1 - 23'd1, Q1 - 23'd1, 8'h55, 23'd1);

    bus.q_i  = Q2;
    bus.mu_i = 24'((64'd1 << 46) / 64'(Q2));
    direct("q2_qm1_sq", Q2 - 23'd1, Q2 - 23'd1, 8'h66, 23'd1);
    direct("q2_qm1_x1", Q2 - 23'd1, 23'd1, 8'h67, Q2 - 23'd1);
    for (int i = 0; i < 500; i++) send(rnd_op(Q2), rnd_op(Q2), 8'(i * 3));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
